// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Multi-cycle sequencer for the HI/LO multiply/divide unit of a 5-stage
//   MIPS pipeline. A MULT/MULTU/DIV/DIVU held in EX is latched, the front of
//   the pipeline is frozen through `stall`, and the 64-bit result is
//   written to HI/LO with a one-cycle `hilo_we` pulse.
//
//   Multiply: iterative shift-add, one multiplier bit per cycle.
//   Divide:   iterative restoring division, one quotient bit per cycle.
//   Signed ops run on magnitudes; the sign is restored on the final cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   EX holds a mul/div instruction
//   op        in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a         in   rs operand (multiplicand / dividend)
//   b         in   rt operand (multiplier / divisor)
//   flush     in   cancels the operation in flight (priority over start)
//   stall     out  freeze request for IF/ID/EX (combinational)
//   hilo_we   out  one-cycle HI/LO write enable
//   hi        out  high product / remainder (registered)
//   lo        out  low product / quotient (registered)
//   div_zero  out  one-cycle divide-by-zero flag
//
// Optional feature
//   MULDIV_FAST_MULT_EN: when defined, MULT/MULTU use a single-cycle
//   combinational multiplier (IDLE -> DONE). Divides stay iterative.

module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_dvz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    // Datapath registers: multiplicand/divisor, accumulator, sign flags.
    logic                 r_is_div;
    logic                 r_sign_q;
    logic                 r_sign_r;
    logic [WIDTH-1:0]     r_opb;
    logic [2*WIDTH-1:0]   r_acc;

    // ------------------------------------------------------------------
    // Input decode (used in IDLE when the instruction is accepted)
    // ------------------------------------------------------------------
    logic                 w_is_signed;
    logic                 w_is_div;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_div_by_zero;
    logic                 w_accept;

    assign w_is_signed   = ~op[0];
    assign w_is_div      = op[1];
    assign w_abs_a       = (w_is_signed && a[WIDTH-1]) ? WIDTH'(-a) : a;
    assign w_abs_b       = (w_is_signed && b[WIDTH-1]) ? WIDTH'(-b) : b;
    assign w_div_by_zero = w_is_div && (b == '0);
    assign w_accept      = (r_state == S_IDLE) && start && !flush;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0]   w_fast_mag;
    logic [2*WIDTH-1:0]   w_fast_prod;

    assign w_fast_mag  = (2*WIDTH)'(w_abs_a) * (2*WIDTH)'(w_abs_b);
    assign w_fast_prod = (w_is_signed && (a[WIDTH-1] ^ b[WIDTH-1])) ? -w_fast_mag : w_fast_mag;
`endif

    // ------------------------------------------------------------------
    // One iteration of the shift-add multiply.
    // Accumulator = {partial product, remaining multiplier bits}.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_addend   = r_acc[0] ? r_opb : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One iteration of the restoring divide.
    // Accumulator = {remainder, dividend bits / quotient bits}.
    // The shifted remainder needs WIDTH+1 bits because it can reach
    // 2*divisor-1 before the trial subtract.
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_div_hi;
    logic                 w_div_fits;
    logic [WIDTH-1:0]     w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_div_hi   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_fits = (w_div_hi >= {1'b0, r_opb});
    // Only evaluated when it fits, so the result is below the divisor.
    assign w_div_diff = w_div_hi[WIDTH-1:0] - r_opb;
    assign w_div_next = w_div_fits ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                   : {w_div_hi[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0]   w_acc_next;
    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    // ------------------------------------------------------------------
    // Sign correction of the final iteration's result.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    assign w_prod_fix = r_sign_q ? -w_acc_next : w_acc_next;
    assign w_quot_fix = r_sign_q ? WIDTH'(-w_acc_next[WIDTH-1:0]) : w_acc_next[WIDTH-1:0];
    assign w_rem_fix  = r_sign_r ? WIDTH'(-w_acc_next[2*WIDTH-1:WIDTH])
                                 : w_acc_next[2*WIDTH-1:WIDTH];
    assign w_res_hi   = r_is_div ? w_rem_fix  : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo   = r_is_div ? w_quot_fix : w_prod_fix[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    if (w_div_by_zero) begin
                        w_state_next = S_DONE;
`ifdef MULDIV_FAST_MULT_EN
                    end else if (!w_is_div) begin
                        w_state_next = S_DONE;
`endif
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_next = S_DONE;
                end
            end
            // A start still high here is the instruction just completed.
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        r_dvz <= w_div_by_zero;
                        if (w_div_by_zero) begin
                            r_hi <= a;
                            r_lo <= '1;
`ifdef MULDIV_FAST_MULT_EN
                        end else if (!w_is_div) begin
                            r_hi <= w_fast_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_fast_prod[WIDTH-1:0];
`endif
                        end
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_div <= w_is_div;
            r_sign_q <= w_is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_sign_r <= w_is_signed && a[WIDTH-1];
            r_opb    <= w_is_div ? w_abs_b : w_abs_a;
            r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. hilo_we/div_zero are gated by flush in the same cycle.
    // ------------------------------------------------------------------
    assign stall    = w_accept || (r_state == S_RUN);
    assign hilo_we  = (r_state == S_DONE) && !flush;
    assign div_zero = hilo_we && r_dvz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed testbench for hilo_muldiv_ctrl. Expected values are hand-computed.
// Latencies adapt to MULDIV_FAST_MULT_EN for MULT/MULTU.

module tb_hilo_muldiv_ctrl;

    localparam int WIDTH = 32;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = WIDTH + 1;
`endif
    localparam int DIV_LAT = WIDTH + 1;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             hilo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    hilo_muldiv_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .stall    (stall),
        .hilo_we  (hilo_we),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op starting in the current cycle (cycle 0). Returns one
    // cycle after the hilo_we pulse (or after a cycle budget) with start low.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit hold, output int n_stall, output int we_cyc,
                         output logic [31:0] h, output logic [31:0] l, output logic dz);
        bit done;
        done    = 1'b0;
        n_stall = 0;
        we_cyc  = -1;
        h       = '0;
        l       = '0;
        dz      = 1'b0;
        start   = 1'b1;
        op      = o;
        a       = x;
        b       = y;
        for (int c = 0; c < 45; c++) begin
            #1;
            if (stall) n_stall++;
            if (hilo_we) begin
                we_cyc = c;
                h      = hi;
                l      = lo;
                dz     = div_zero;
                done   = 1'b1;
            end
            tick();
            if (!hold || done) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] o,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input int lat, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo, input logic exp_dz);
        int          ns;
        int          wc;
        logic [31:0] h;
        logic [31:0] l;
        logic        dz;
        do_op(o, x, y, 1'b0, ns, wc, h, l, dz);
        check({tag, ".we_cycle"}, 64'(wc), 64'(lat));
        check({tag, ".stall_cycles"}, 64'(ns), 64'(lat));
        check({tag, ".hi"}, 64'(h), 64'(exp_hi));
        check({tag, ".lo"}, 64'(l), 64'(exp_lo));
        check({tag, ".div_zero"}, 64'(dz), 64'(exp_dz));
    endtask

    int          ns;
    int          wc;
    int          n_we;
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("reset.stall",    64'(stall),    64'd0);
        check("reset.hilo_we",  64'(hilo_we),  64'd0);
        check("reset.div_zero", 64'(div_zero), 64'd0);
        check("reset.hi",       64'(hi),       64'd0);
        check("reset.lo",       64'(lo),       64'd0);
        tick();

        // Main function
        run_and_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,
                      32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_and_check("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, MUL_LAT,
                      32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_and_check("mult_neg5xneg6", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, MUL_LAT,
                      32'h0000_0000, 32'd30, 1'b0);
        run_and_check("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_and_check("div_7byneg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_LAT,
                      32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_and_check("divu_100by7", OP_DIVU, 32'd100, 32'd7, DIV_LAT,
                      32'd2, 32'd14, 1'b0);
        run_and_check("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,
                      32'h0000_0000, 32'h8000_0000, 1'b0);
        run_and_check("divu_by_zero", OP_DIVU, 32'h0000_1234, 32'd0, 1,
                      32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        // Back-to-back: accepted in the IDLE cycle right after the previous DONE
        run_and_check("b2b_multu", OP_MULTU, 32'd3, 32'd4, MUL_LAT,
                      32'd0, 32'd12, 1'b0);

        // Flush mid-divide at cycle 10
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd100;
        b     = 32'd7;
        n_we  = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (hilo_we) n_we++;
            tick();
            start = 1'b0;
        end
        flush = 1'b1;
        #1;
        check("flush.stall_in_flush_cycle", 64'(stall), 64'd1);
        if (hilo_we) n_we++;
        tick();
        flush = 1'b0;
        #1;
        check("flush.stall_after", 64'(stall), 64'd0);
        for (int c = 0; c < 40; c++) begin
            if (hilo_we) n_we++;
            tick();
        end
        check("flush.no_hilo_we", 64'(n_we), 64'd0);
        run_and_check("after_flush_multu", OP_MULTU, 32'd6, 32'd7, MUL_LAT,
                      32'd0, 32'd42, 1'b0);

        // Flush in the DONE cycle of a divide by zero suppresses the write
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd5;
        b     = 32'd0;
        tick();
        start = 1'b0;
        flush = 1'b1;
        #1;
        check("flush_done.hilo_we", 64'(hilo_we), 64'd0);
        check("flush_done.div_zero", 64'(div_zero), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_done.stall_after", 64'(stall), 64'd0);
        tick();

        // start held through DONE -> exactly one pulse, no restart
        do_op(OP_MULTU, 32'd9, 32'd9, 1'b1, ns, wc, h, l, dz);
        check("hold.we_cycle", 64'(wc), 64'(MUL_LAT));
        check("hold.lo", 64'(l), 64'd81);
        #1;
        check("hold.no_restart_stall", 64'(stall), 64'd0);
        n_we = 0;
        for (int c = 0; c < 40; c++) begin
            if (hilo_we) n_we++;
            tick();
        end
        check("hold.extra_we", 64'(n_we), 64'd0);

        // Synchronous reset mid-RUN at cycle 5
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd1000;
        b     = 32'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_run.stall",    64'(stall),    64'd0);
        check("rst_run.hilo_we",  64'(hilo_we),  64'd0);
        check("rst_run.div_zero", 64'(div_zero), 64'd0);
        check("rst_run.hi",       64'(hi),       64'd0);
        check("rst_run.lo",       64'(lo),       64'd0);
        n_we = 0;
        for (int c = 0; c < 40; c++) begin
            if (hilo_we) n_we++;
            tick();
        end
        check("rst_run.no_resume", 64'(n_we), 64'd0);
        run_and_check("after_rst_divu", OP_DIVU, 32'd1000, 32'd3, DIV_LAT,
                      32'd1, 32'd333, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
